// File: rtl/matmul_output_writer.sv
// Write-back stage below the systolic array: de-skews column outputs into whole
// rows, optionally adds the matching psum row, and writes rows to output memory.

// Per-column delay line used to realign the skewed array outputs.
module matmul_output_writer_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;

  // Shift the column sample one slot deeper every cycle.
  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    vld_d[0] = in_vld;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Delay-line registers; cleared on reset so no stale column survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = dat_q[DEPTH-1];
endmodule

module matmul_output_writer #(
  parameter int WIDTH  = 8,
  parameter int COL    = 4,
  parameter int O_SIZE = 256,
  localparam int AW    = $clog2(O_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AW-1:0]             cfg_rows,
  input  logic [AW-1:0]             cfg_psum_offset,
  input  logic [AW-1:0]             cfg_o_offset,
  input  logic                      cfg_accum_en,
  input  logic [COL-1:0]            arr_valid,
  input  logic [COL-1:0][WIDTH-1:0] arr_out,
  output logic                      psum_rd_en,
  output logic [AW-1:0]             psum_rd_addr,
  input  logic [COL-1:0][WIDTH-1:0] psum_rd_data,
  output logic                      o_wr_en,
  output logic [AW-1:0]             o_wr_addr,
  output logic [COL-1:0][WIDTH-1:0] o_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  // Pipeline: [1] aligned row issues psum read, [2] waits for read data,
  // [3] holds the finished row being written.
  localparam int STAGES = 3;

  typedef logic [COL-1:0][WIDTH-1:0] row_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rows_q, rows_d, poff_q, poff_d, ooff_q, ooff_d, cnt_q, cnt_d;
  logic            accum_q, accum_d, err_q, err_d;
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  row_t            a_row_q, a_row_d, p_row_q, p_row_d, wr_data_q, wr_data_d;
  logic [AW-1:0]   a_idx_q, a_idx_d, p_idx_q, p_idx_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  logic [COL-1:0]  al_vld;
  row_t            al_row;
  logic            all_v, any_v, accept;

  // Column c is delayed COL-1-c cycles; the last column needs no delay.
  for (genvar c = 0; c < COL - 1; c++) begin : g_lane
    matmul_output_writer_lane #(.WIDTH(WIDTH), .DEPTH(COL - 1 - c)) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (arr_valid[c]),
      .in_data (arr_out[c]),
      .out_vld (al_vld[c]),
      .out_data(al_row[c])
    );
  end
  assign al_vld[COL-1] = arr_valid[COL-1];
  assign al_row[COL-1] = arr_out[COL-1];

  assign all_v = &al_vld;
  assign any_v = |al_vld;

  // Control FSM, error tracking and the row pipeline next-state.
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    poff_d     = poff_q;
    ooff_d     = ooff_q;
    accum_d    = accum_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    accept     = all_v && (state_q == S_RUN);

    // Partial alignment, or a whole row outside RUN, is a protocol error.
    if ((any_v && !all_v) || (all_v && state_q != S_RUN)) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RUN;
        rows_d  = cfg_rows;
        poff_d  = cfg_psum_offset;
        ooff_d  = cfg_o_offset;
        accum_d = cfg_accum_en;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      S_RUN: if (accept) begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == rows_q) state_d = S_DRAIN;
      end
      // Leave once only the write stage can still hold a row: done then
      // lands in the cycle right after that last write.
      S_DRAIN: if (!vld_pipe_q[1] && !vld_pipe_q[2]) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    vld_pipe_d = {vld_pipe_q[STAGES-1:1], accept};

    a_row_d   = accept ? al_row : a_row_q;
    a_idx_d   = accept ? cnt_q : a_idx_q;
    rd_addr_d = accept ? poff_q + cnt_q : rd_addr_q;

    p_row_d   = a_row_q;
    p_idx_d   = a_idx_q;

    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (vld_pipe_q[2]) begin
      wr_addr_d = ooff_q + p_idx_q;
      for (int e = 0; e < COL; e++)
        wr_data_d[e] = accum_q ? p_row_q[e] + psum_rd_data[e] : p_row_q[e];
    end
  end

  // State, config and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      poff_q     <= '0;
      ooff_q     <= '0;
      accum_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
      a_row_q    <= '0;
      a_idx_q    <= '0;
      p_row_q    <= '0;
      p_idx_q    <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      poff_q     <= poff_d;
      ooff_q     <= ooff_d;
      accum_q    <= accum_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
      a_row_q    <= a_row_d;
      a_idx_q    <= a_idx_d;
      p_row_q    <= p_row_d;
      p_idx_q    <= p_idx_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign psum_rd_en   = vld_pipe_q[1] & accum_q;
  assign psum_rd_addr = rd_addr_q;
  assign o_wr_en      = vld_pipe_q[3];
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;
endmodule
